fb_pixel_writer: RTL

// Downstream of pixel_pipeline: consumes its serialised R/G/B + valid_pix stream.

---
 rtl/fb_pkg.sv | 30 +++
 rtl/pixel_fifo.sv | 75 +++++++
 rtl/fb_pixel_writer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// ============================================================================
//  fb_pkg : shared pixel types, FSM encoding and colour helpers
//  Rev 1.0
// ============================================================================
`default_nettype none

package fb_pkg;

   localparam int PIX_W = 24;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } fb_state_e;

   function automatic logic [15:0] to_rgb565(input pixel_t p);
      return {p.r[7:3], p.g[7:2], p.b[7:3]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_fifo.sv
// ============================================================================
//  pixel_fifo : synchronous pixel FIFO with flush (push during flush is kept)
//  Rev 1.0
// ============================================================================
`default_nettype none

module pixel_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  pixel_t                   push_data,
   input  logic                     pop,
   output pixel_t                   pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] wr_idx;
   logic          do_push, do_pop;
   pixel_t        mem_q [DEPTH];

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign level    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && !empty && !flush;
      // A full FIFO still takes a pixel when one leaves in the same cycle
      do_push  = push && (flush || !full || do_pop);
      wr_idx   = flush ? '0 : wr_ptr_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = push ? AW'(1) : '0;
         count_d  = push ? (AW+1)'(1) : '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_idx] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/fb_pixel_writer.sv
// ============================================================================
//  fb_pixel_writer : buffers a pixel stream, tracks raster position and writes
//  packed words to a framebuffer. Define FB_RGB565_EN for two RGB565 pixels/word.
//  Rev 1.0
// ============================================================================
`default_nettype none

module fb_pixel_writer
   import fb_pkg::*;
#(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 20,
   parameter int BASE_ADDR  = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          frame_start,
   input  logic                          valid_pix,
   input  logic [7:0]                    R,
   input  logic [7:0]                    G,
   input  logic [7:0]                    B,
   output logic                          mem_wr_valid,
   input  logic                          mem_wr_ready,
   output logic [ADDR_W-1:0]             mem_wr_addr,
   output logic [31:0]                   mem_wr_data,
   output logic                          frame_done,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = $clog2(V_RES + 1);

   fb_state_e          state_q, state_d;
   logic [XW-1:0]      x_q, x_d;
   logic [YW-1:0]      y_q, y_d;
   logic [ADDR_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [31:0]        data_q, data_d;
   logic               last_q, last_d;
   logic               overflow_q, overflow_d;
`ifdef FB_RGB565_EN
   logic [15:0]        lo_q, lo_d;
`endif

   logic    push, pop, flush;
   logic    fifo_full, fifo_empty;
   logic    end_of_line, end_of_frame;
   pixel_t  in_pix, out_pix;

   assign in_pix = '{r: R, g: G, b: B};
   // Pixels are only buffered while a frame is open (or opening this cycle)
   assign push   = valid_pix && (frame_start || state_q == RUN || state_q == WRITE);

   pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_data (in_pix),
      .pop       (pop),
      .pop_data  (out_pix),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      last_d     = last_q;
      overflow_d = overflow_q;
      pop        = 1'b0;
      flush      = 1'b0;
`ifdef FB_RGB565_EN
      lo_d       = lo_q;
`endif
      end_of_line  = (x_q == XW'(H_RES - 1));
      end_of_frame = end_of_line && (y_q == YW'(V_RES - 1));

      if (frame_start) begin
         flush      = 1'b1;
         state_d    = RUN;
         x_d        = '0;
         y_d        = '0;
         cnt_d      = ADDR_W'(BASE_ADDR);
         overflow_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            RUN: begin
               if (!fifo_empty) begin
                  pop = 1'b1;
                  if (end_of_line) begin
                     x_d = '0;
                     y_d = y_q + 1'b1;
                  end else begin
                     x_d = x_q + 1'b1;
                  end
`ifdef FB_RGB565_EN
                  // Even x fills the low half; odd x completes the word
                  if (!x_q[0]) begin
                     lo_d = to_rgb565(out_pix);
                  end else begin
                     data_d  = {to_rgb565(out_pix), lo_q};
                     addr_d  = cnt_q;
                     last_d  = end_of_frame;
                     state_d = WRITE;
                  end
`else
                  data_d  = {{(32-PIX_W){1'b0}}, out_pix};
                  addr_d  = cnt_q;
                  last_d  = end_of_frame;
                  state_d = WRITE;
`endif
               end
            end
            WRITE: begin
               if (mem_wr_ready) begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = last_q ? DONE : RUN;
               end
            end
            DONE: begin
               // Anything still queued belongs past the frame's end
               flush   = 1'b1;
               state_d = IDLE;
            end
            default: ;
         endcase
         if (push && fifo_full && !pop) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         cnt_q      <= ADDR_W'(BASE_ADDR);
         addr_q     <= '0;
         data_q     <= '0;
         last_q     <= 1'b0;
         overflow_q <= 1'b0;
`ifdef FB_RGB565_EN
         lo_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         last_q     <= last_d;
         overflow_q <= overflow_d;
`ifdef FB_RGB565_EN
         lo_q       <= lo_d;
`endif
      end
   end

   assign mem_wr_valid = (state_q == WRITE);
   assign mem_wr_addr  = addr_q;
   assign mem_wr_data  = data_q;
   assign frame_done   = (state_q == DONE);
   assign overflow     = overflow_q;

endmodule

`default_nettype wire
